// File: rtl/sram_fb_pkg.sv
// Shared types and helpers for the framebuffer write path.
// Geometry, request payload, writer FSM states, address mapping.
package sram_fb_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_WORDS = H_RES * V_RES;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] color;
  } pixel_req_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    NEXT
  } wr_state_t;

  // y*320 + x without a multiplier
  function automatic logic [17:0] fb_addr(
    input logic [8:0] x,
    input logic [8:0] y
  );
    logic [17:0] yw;
    yw = {9'd0, y};
    return (yw << 8) + (yw << 6) + {9'd0, x};
  endfunction

endpackage

// File: rtl/sram_pixel_writer_if.sv
// Request, clear, arbiter and SRAM write bus of the pixel writer.
// master = game logic / arbiter / SRAM side, slave = the writer.
interface sram_pixel_writer_if;

  logic        iReq_Valid;
  logic        oReq_Ready;
  logic [8:0]  iReq_X;
  logic [8:0]  iReq_Y;
  logic [15:0] iReq_Color;
  logic        iClear_Start;
  logic [15:0] iClear_Color;
  logic        oClear_Done;
  logic        iBus_Grant;
  logic        oBus_Req;
  logic        oBus_Busy;
  logic [17:0] oSRAM_ADDR;
  logic [15:0] oSRAM_DQ;
  logic        oSRAM_DQ_OE;
  logic        oSRAM_WE_N;
  logic        oErr_Range;

  modport master (
    output iReq_Valid, iReq_X, iReq_Y, iReq_Color,
    output iClear_Start, iClear_Color, iBus_Grant,
    input  oReq_Ready, oClear_Done, oBus_Req, oBus_Busy,
    input  oSRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE, oSRAM_WE_N,
    input  oErr_Range
  );

  modport slave (
    input  iReq_Valid, iReq_X, iReq_Y, iReq_Color,
    input  iClear_Start, iClear_Color, iBus_Grant,
    output oReq_Ready, oClear_Done, oBus_Req, oBus_Busy,
    output oSRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE, oSRAM_WE_N,
    output oErr_Range
  );

endinterface

// File: rtl/pixel_req_fifo.sv
// Synchronous request FIFO holding pixel_req_t entries.
// Flags come from the registered count; no push/pop bypass.
module pixel_req_fifo
  import sram_fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  pixel_req_t             data_i,
  input  logic                   pop_i,
  output pixel_req_t             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  pixel_req_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/sram_pixel_writer.sv
// Queues pixel writes and framebuffer fills, and runs 4-cycle
// SRAM write cycles while the arbiter grants the bus.
module sram_pixel_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_RES      = sram_fb_pkg::H_RES,
  parameter int V_RES      = sram_fb_pkg::V_RES
) (
  input logic                iCLK,
  input logic                iRST_N,
  sram_pixel_writer_if.slave bus
);

  import sram_fb_pkg::*;

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0]  HMAX    = 9'(H_RES);
  localparam logic [8:0]  VMAX    = 9'(V_RES);
  localparam logic [17:0] CLR_END = 18'(H_RES * V_RES);

  wr_state_t   state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic [17:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] clr_col_q, clr_col_d;
  logic        clr_act_q, clr_act_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  pixel_req_t  req_in, head;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;

  logic pix_ok, push_fire, pix_push;
  logic has_work, can_go, go_clr, go_pix;
  logic clr_acc, clr_last, busy;

  assign req_in = '{x: bus.iReq_X, y: bus.iReq_Y,
                    color: bus.iReq_Color};

  assign pix_ok    = (bus.iReq_X < HMAX) && (bus.iReq_Y < VMAX);
  assign push_fire = bus.iReq_Valid && !fifo_full;
  assign pix_push  = push_fire && pix_ok;

  pixel_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .push_i  (pix_push),
    .data_i  (req_in),
    .pop_i   (go_pix),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // while a fill is active every launched write is a fill write
  assign has_work = clr_act_q || (fifo_cnt != '0);
  assign can_go   = bus.iBus_Grant && has_work &&
                    (state_q == IDLE || state_q == NEXT);
  assign go_clr   = can_go && clr_act_q;
  assign go_pix   = can_go && !clr_act_q;
  assign clr_acc  = bus.iClear_Start && (state_q == IDLE) &&
                    fifo_empty && !clr_act_q;
  assign clr_last = (state_q == HOLD) && clr_act_q &&
                    (clr_cnt_q == CLR_END);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, NEXT: state_d = can_go ? SETUP : IDLE;
      SETUP:      state_d = STROBE;
      STROBE:     state_d = HOLD;
      HOLD:       state_d = NEXT;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.oSRAM_WE_N  = 1'b1;
    bus.oSRAM_DQ_OE = 1'b0;
    busy            = 1'b0;
    unique case (state_q)
      SETUP, HOLD: begin
        bus.oSRAM_DQ_OE = 1'b1;
        busy            = 1'b1;
      end
      STROBE: begin
        bus.oSRAM_WE_N  = 1'b0;
        bus.oSRAM_DQ_OE = 1'b1;
        busy            = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    dq_d      = dq_q;
    clr_cnt_d = clr_cnt_q;
    clr_col_d = clr_col_q;
    clr_act_d = clr_act_q;
    unique case (1'b1)
      clr_acc: begin
        clr_cnt_d = '0;
        clr_col_d = bus.iClear_Color;
        clr_act_d = 1'b1;
      end
      go_clr: begin
        addr_d    = clr_cnt_q;
        dq_d      = clr_col_q;
        clr_cnt_d = clr_cnt_q + 18'd1;
      end
      go_pix: begin
        addr_d = fb_addr(head.x, head.y);
        dq_d   = head.color;
      end
      clr_last: clr_act_d = 1'b0;
      default: ;
    endcase
  end

  assign done_d = clr_last;
  assign err_d  = push_fire && !pix_ok;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      addr_q    <= '0;
      dq_q      <= '0;
      clr_cnt_q <= '0;
      clr_col_q <= '0;
      clr_act_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      dq_q      <= dq_d;
      clr_cnt_q <= clr_cnt_d;
      clr_col_q <= clr_col_d;
      clr_act_q <= clr_act_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.oReq_Ready  = !fifo_full;
  assign bus.oBus_Req    = has_work || busy;
  assign bus.oBus_Busy   = busy;
  assign bus.oSRAM_ADDR  = addr_q;
  assign bus.oSRAM_DQ    = dq_q;
  assign bus.oClear_Done = done_q;
  assign bus.oErr_Range  = err_q;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Directed bench for sram_pixel_writer on a 320x8 framebuffer
// so that full fills stay short.
module tb_sram_pixel_writer;

  localparam int VR = 8;
  localparam int NW = 320 * VR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_pixel_writer_if bus();

  sram_pixel_writer #(
    .FIFO_DEPTH (16),
    .H_RES      (320),
    .V_RES      (VR)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int viol = 0;
  logic [17:0] wa[$];
  logic [15:0] wd[$];

  localparam logic [40:0] RST_V =
    {1'b1, 1'b0, 18'd0, 16'd0, 5'b00001};

  // SRAM model and arbiter-side monitors
  always @(posedge clk) begin
    if (!bus.oSRAM_WE_N) begin
      wa.push_back(bus.oSRAM_ADDR);
      wd.push_back(bus.oSRAM_DQ);
    end
    if (bus.oClear_Done) done_cnt++;
    if (bus.oBus_Busy && !bus.iBus_Grant) viol++;
  end

  function automatic logic [40:0] outv();
    return {bus.oSRAM_WE_N, bus.oSRAM_DQ_OE, bus.oSRAM_ADDR,
            bus.oSRAM_DQ, bus.oBus_Req, bus.oBus_Busy,
            bus.oClear_Done, bus.oErr_Range, bus.oReq_Ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y,
                      input logic [15:0] c);
    bus.iReq_Valid = 1'b1;
    bus.iReq_X     = 9'(x);
    bus.iReq_Y     = 9'(y);
    bus.iReq_Color = c;
    tick();
    bus.iReq_Valid = 1'b0;
  endtask

  task automatic start_clear(input logic [15:0] c);
    bus.iClear_Start = 1'b1;
    bus.iClear_Color = c;
    tick();
    bus.iClear_Start = 1'b0;
    bus.iClear_Color = 16'h0;
  endtask

  task automatic test_reset();
    logic [40:0] v;
    rst_n = 1'b0;
    repeat (2) tick();
    v = outv();
    n_chk++;
    if (v !== RST_V) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", v, RST_V);
    end
    rst_n = 1'b1;
    tick();
    v = outv();
    n_chk++;
    if (v !== RST_V) begin
      n_fail++;
      $display("FAIL reset_rel: got %h want %h", v, RST_V);
    end
  endtask

  task automatic test_single();
    logic [36:0] v;
    bus.iBus_Grant = 1'b1;
    wa.delete();
    wd.delete();
    push(5, 2, 16'h7FFF);
    n_chk++;
    if (bus.oBus_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy %b want 0", bus.oBus_Busy);
    end
    tick();
    v = {bus.oBus_Busy, bus.oSRAM_DQ_OE, bus.oSRAM_WE_N,
         bus.oSRAM_ADDR, bus.oSRAM_DQ};
    n_chk++;
    if (v !== {3'b111, 18'd645, 16'h7FFF}) begin
      n_fail++;
      $display("FAIL single_setup: got %h want %h",
               v, {3'b111, 18'd645, 16'h7FFF});
    end
    tick();
    v = {bus.oBus_Busy, bus.oSRAM_DQ_OE, bus.oSRAM_WE_N,
         bus.oSRAM_ADDR, bus.oSRAM_DQ};
    n_chk++;
    if (v !== {3'b110, 18'd645, 16'h7FFF}) begin
      n_fail++;
      $display("FAIL single_strobe: got %h want %h",
               v, {3'b110, 18'd645, 16'h7FFF});
    end
    tick();
    v = {bus.oBus_Busy, bus.oSRAM_DQ_OE, bus.oSRAM_WE_N,
         bus.oSRAM_ADDR, bus.oSRAM_DQ};
    n_chk++;
    if (v !== {3'b111, 18'd645, 16'h7FFF}) begin
      n_fail++;
      $display("FAIL single_hold: got %h want %h",
               v, {3'b111, 18'd645, 16'h7FFF});
    end
    tick();
    n_chk++;
    if ({bus.oBus_Busy, bus.oSRAM_DQ_OE, bus.oSRAM_WE_N}
        !== 3'b001) begin
      n_fail++;
      $display("FAIL single_next: busy/oe/we %b want 001",
               {bus.oBus_Busy, bus.oSRAM_DQ_OE, bus.oSRAM_WE_N});
    end
    tick();
    n_chk++;
    if (wa.size() != 1) begin
      n_fail++;
      $display("FAIL single_pulses: got %0d want 1", wa.size());
    end
  endtask

  task automatic test_range();
    wa.delete();
    wd.delete();
    push(320, 0, 16'h1111);
    n_chk++;
    if (bus.oErr_Range !== 1'b1) begin
      n_fail++;
      $display("FAIL range_x: err %b want 1", bus.oErr_Range);
    end
    push(0, 240, 16'h2222);
    n_chk++;
    if (bus.oErr_Range !== 1'b1) begin
      n_fail++;
      $display("FAIL range_y: err %b want 1", bus.oErr_Range);
    end
    push(0, VR, 16'h3333);
    n_chk++;
    if (bus.oErr_Range !== 1'b1) begin
      n_fail++;
      $display("FAIL range_yedge: err %b want 1", bus.oErr_Range);
    end
    tick();
    n_chk++;
    if ({bus.oErr_Range, bus.oBus_Req} !== 2'b00) begin
      n_fail++;
      $display("FAIL range_after: err/req %b want 00",
               {bus.oErr_Range, bus.oBus_Req});
    end
    repeat (6) tick();
    n_chk++;
    if (wa.size() != 0) begin
      n_fail++;
      $display("FAIL range_nowrite: got %0d want 0", wa.size());
    end
    push(319, VR - 1, 16'h1234);
    n_chk++;
    if (bus.oErr_Range !== 1'b0) begin
      n_fail++;
      $display("FAIL range_edge_err: err %b want 0",
               bus.oErr_Range);
    end
    repeat (6) tick();
    n_chk++;
    if (wa.size() != 1 || wa[0] !== 18'd2559 ||
        wd[0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL range_edge_wr: n %0d addr %0d want 1 2559",
               wa.size(), wa[0]);
    end
  endtask

  task automatic test_full();
    int cyc;
    int bad;
    bus.iBus_Grant = 1'b0;
    wa.delete();
    wd.delete();
    for (int i = 0; i < 16; i++)
      push(i * 3, i % 8, 16'h1000 + 16'(i));
    n_chk++;
    if ({bus.oReq_Ready, bus.oBus_Req} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_flags: ready/req %b want 01",
               {bus.oReq_Ready, bus.oBus_Req});
    end
    push(1, 1, 16'hDEAD);
    n_chk++;
    if (bus.oErr_Range !== 1'b0) begin
      n_fail++;
      $display("FAIL full_noerr: err %b want 0", bus.oErr_Range);
    end
    repeat (4) tick();
    n_chk++;
    if (wa.size() != 0 || bus.oBus_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_nogrant: writes %0d busy %b want 0 0",
               wa.size(), bus.oBus_Busy);
    end
    bus.iBus_Grant = 1'b1;
    tick();
    cyc = 1;
    n_chk++;
    if (bus.oReq_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_pop: ready %b want 1",
               bus.oReq_Ready);
    end
    while (bus.oBus_Req && cyc < 200) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (cyc != 64) begin
      n_fail++;
      $display("FAIL full_cycles: got %0d want 64", cyc);
    end
    bad = (wa.size() == 16) ? 0 : 1;
    for (int i = 0; i < 16 && i < wa.size(); i++)
      if (wa[i] !== 18'((i % 8) * 320 + i * 3) ||
          wd[i] !== 16'h1000 + 16'(i)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_order: %0d bad of %0d want 0 of 16",
               bad, wa.size());
    end
  endtask

  task automatic test_clear_ignored();
    bus.iBus_Grant = 1'b0;
    wa.delete();
    wd.delete();
    done_cnt = 0;
    push(1, 0, 16'h0AAA);
    start_clear(16'h7C00);
    bus.iBus_Grant = 1'b1;
    repeat (12) tick();
    n_chk++;
    if (wa.size() != 1 || wa[0] !== 18'd1 || done_cnt != 0 ||
        bus.oBus_Req !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ignored: n %0d done %0d req %b want 1 0 0",
               wa.size(), done_cnt, bus.oBus_Req);
    end
  endtask

  task automatic test_clear();
    int cyc;
    int bad;
    logic [1:0] prev;
    bus.iBus_Grant = 1'b1;
    wa.delete();
    wd.delete();
    done_cnt = 0;
    start_clear(16'h001F);
    repeat (40) tick();
    n_chk++;
    if (bus.oReq_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ready: ready %b want 1", bus.oReq_Ready);
    end
    push(7, 3, 16'h4321);
    cyc = 0;
    prev = 2'b00;
    while (!bus.oClear_Done && cyc < 20000) begin
      prev = {bus.oSRAM_DQ_OE, bus.oSRAM_WE_N};
      tick();
      cyc++;
    end
    n_chk++;
    if (bus.oClear_Done !== 1'b1 || prev !== 2'b11 ||
        bus.oSRAM_DQ_OE !== 1'b0 || wa.size() != NW) begin
      n_fail++;
      $display("FAIL clr_done: done %b prev %b n %0d want 1 11 %0d",
               bus.oClear_Done, prev, wa.size(), NW);
    end
    repeat (8) tick();
    bad = (wa.size() == NW + 1) ? 0 : 1;
    for (int i = 0; i < NW && i < wa.size(); i++)
      if (wa[i] !== 18'(i) || wd[i] !== 16'h001F) bad++;
    n_chk++;
    if (bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL clr_fill: bad %0d done %0d want 0 1",
               bad, done_cnt);
    end
    n_chk++;
    if (wa.size() != NW + 1 || wa[NW] !== 18'd967 ||
        wd[NW] !== 16'h4321) begin
      n_fail++;
      $display("FAIL clr_queued: n %0d addr %0d want %0d 967",
               wa.size(), wa[NW], NW + 1);
    end
  endtask

  task automatic test_grant_toggle();
    int cyc;
    int n0;
    int bad;
    bus.iBus_Grant = 1'b1;
    wa.delete();
    wd.delete();
    done_cnt = 0;
    start_clear(16'h03E0);
    cyc = 0;
    while ((wa.size() < 100 || bus.oBus_Busy) && cyc < 1000) begin
      tick();
      cyc++;
    end
    bus.iBus_Grant = 1'b0;
    n0 = wa.size();
    repeat (10) tick();
    n_chk++;
    if ({bus.oBus_Busy, bus.oBus_Req} !== 2'b01 ||
        wa.size() != n0) begin
      n_fail++;
      $display("FAIL tog_park: busy/req %b writes +%0d want 01 +0",
               {bus.oBus_Busy, bus.oBus_Req}, wa.size() - n0);
    end
    bus.iBus_Grant = 1'b1;
    cyc = 0;
    while (!bus.oClear_Done && cyc < 20000) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    bad = (wa.size() == NW) ? 0 : 1;
    for (int i = 0; i < NW && i < wa.size(); i++)
      if (wa[i] !== 18'(i) || wd[i] !== 16'h03E0) bad++;
    n_chk++;
    if (bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL tog_resume: bad %0d n %0d done %0d want 0 %0d 1",
               bad, wa.size(), done_cnt, NW);
    end
  endtask

  task automatic test_simul();
    int cyc;
    bus.iBus_Grant = 1'b1;
    wa.delete();
    wd.delete();
    done_cnt = 0;
    bus.iClear_Start = 1'b1;
    bus.iClear_Color = 16'h5555;
    bus.iReq_Valid   = 1'b1;
    bus.iReq_X       = 9'd10;
    bus.iReq_Y       = 9'd1;
    bus.iReq_Color   = 16'h2222;
    tick();
    bus.iClear_Start = 1'b0;
    bus.iReq_Valid   = 1'b0;
    cyc = 0;
    while (!bus.oClear_Done && cyc < 20000) begin
      tick();
      cyc++;
    end
    repeat (8) tick();
    n_chk++;
    if (wa.size() != NW + 1 || wa[0] !== 18'd0 ||
        wd[0] !== 16'h5555 || wa[NW] !== 18'd330 ||
        wd[NW] !== 16'h2222 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL simul: n %0d last %0d done %0d want %0d 330 1",
               wa.size(), wa[NW], done_cnt, NW + 1);
    end
  endtask

  task automatic test_reset_strobe();
    int cyc;
    logic [40:0] v;
    bus.iBus_Grant = 1'b0;
    wa.delete();
    wd.delete();
    push(5, 2, 16'hAAAA);
    push(6, 2, 16'hBBBB);
    bus.iBus_Grant = 1'b1;
    cyc = 0;
    while (bus.oSRAM_WE_N && cyc < 20) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (bus.oSRAM_WE_N !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reach: we_n %b want 0", bus.oSRAM_WE_N);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.oSRAM_WE_N, bus.oSRAM_DQ_OE} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_async: we/oe %b want 10",
               {bus.oSRAM_WE_N, bus.oSRAM_DQ_OE});
    end
    tick();
    rst_n = 1'b1;
    tick();
    v = outv();
    n_chk++;
    if (v !== RST_V) begin
      n_fail++;
      $display("FAIL rst_after: got %h want %h", v, RST_V);
    end
    repeat (10) tick();
    n_chk++;
    if (wa.size() != 0) begin
      n_fail++;
      $display("FAIL rst_nowrite: got %0d want 0", wa.size());
    end
  endtask

  initial begin
    bus.iReq_Valid   = 1'b0;
    bus.iReq_X       = '0;
    bus.iReq_Y       = '0;
    bus.iReq_Color   = '0;
    bus.iClear_Start = 1'b0;
    bus.iClear_Color = '0;
    bus.iBus_Grant   = 1'b0;
    test_reset();
    test_single();
    test_range();
    test_full();
    test_clear_ignored();
    test_clear();
    test_grant_toggle();
    test_simul();
    test_reset_strobe();
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL busy_no_grant: got %0d want 0", viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_pixel_writer.md
Name: sram_pixel_writer

Overview:
Write-side counterpart to the framebuffer reader (`drawer`) in the snake design. It accepts pixel write requests (x, y, colour) from game logic through a valid/ready FIFO and performs timed SRAM write cycles. It also fills the whole 320x240 framebuffer with one colour on command. It owns the SRAM bus only while the external arbiter grants it, typically during vertical blanking.

Parameters:
FIFO_DEPTH, 16, request FIFO entries (power of 2, >=2)
H_RES, 320, framebuffer width in pixels
V_RES, 240, framebuffer height in pixels

Ports:
iCLK  in  1  system clock (25.2 MHz VGA domain)
iRST_N  in  1  asynchronous active-low reset
iReq_Valid  in  1  pixel request valid
oReq_Ready  out  1  FIFO not full
iReq_X  in  9  pixel column
iReq_Y  in  9  pixel row
iReq_Color  in  16  pixel colour, bit15 unused, 14:0 = R5 G5 B5
iClear_Start  in  1  single-cycle pulse: fill framebuffer
iClear_Color  in  16  fill colour, sampled with iClear_Start
oClear_Done  out  1  1-cycle pulse after last fill write
iBus_Grant  in  1  arbiter grants SRAM bus (level)
oBus_Req  out  1  writer has pending work
oBus_Busy  out  1  write cycle in progress; arbiter must not revoke grant while high
oSRAM_ADDR  out  18  SRAM word address
oSRAM_DQ  out  16  write data
oSRAM_DQ_OE  out  1  drive DQ (top level tristates SRAM_DQ)
oSRAM_WE_N  out  1  SRAM write enable, active low
oErr_Range  out  1  1-cycle pulse: out-of-range request discarded

Behaviour:
- Reset (async, iRST_N low) forces:
  - oSRAM_WE_N=1, oSRAM_DQ_OE=0, oSRAM_ADDR=0, oSRAM_DQ=0
  - oBus_Req=0, oBus_Busy=0, oClear_Done=0, oErr_Range=0
  - FIFO empty, FSM in IDLE
  - Reset mid-write aborts immediately; that pixel is lost.
- FIFO:
  - Push when iReq_Valid & oReq_Ready.
  - oReq_Ready = !full; it stays valid during a clear.
  - Push and pop in the same cycle while full is allowed only if the pop frees the slot first, i.e. ready is computed from the registered count (no bypass).
- Range check at push:
  - x>=H_RES or y>=V_RES → entry not stored; oErr_Range pulses the cycle after the handshake.
- Address:
  - addr = y*320 + x, computed as (y<<8)+(y<<6)+x, 18-bit unsigned; max 76799.
- FSM states: IDLE, SETUP, STROBE, HOLD, NEXT.
  - IDLE: oBus_Req = (clear_active | !empty). If iBus_Grant & clear_active → SETUP with addr=clr_cnt. Else if iBus_Grant & !empty → pop, SETUP.
  - SETUP: ADDR/DQ valid, DQ_OE=1, WE_N=1, Busy=1.
  - STROBE: WE_N=0 for exactly one cycle; ADDR/DQ stable.
  - HOLD: WE_N=1, DQ_OE=1, ADDR/DQ stable.
  - NEXT: DQ_OE=0, Busy=0. If work remains and iBus_Grant → SETUP; else → IDLE.
  - One pixel = 4 cycles; sustained throughput 1 pixel per 4 clocks.
- Grant sampling:
  - iBus_Grant is sampled only in IDLE and NEXT.
  - Grant revoked while Busy is an arbiter protocol violation; the writer still completes the cycle (the bench flags it).
- Clear:
  - iClear_Start is accepted only when FSM in IDLE, FIFO empty and no clear active; otherwise ignored.
  - On accept: clr_cnt=0, colour latched, clear_active=1.
  - Clear takes priority over the FIFO; pushes during a clear queue up and drain after it.
  - The final write (addr 76799) finishes in HOLD; oClear_Done pulses in the following NEXT cycle and clear_active drops then.
- Simultaneous iClear_Start and a push in the same cycle: the push is accepted, so the FIFO is not empty next cycle. The clear is still accepted, because the accept check uses the pre-push empty flag. Draw order is clear first, then pixel.

Decomposition:
- Package sram_fb_pkg:
  - H_RES/V_RES localparams
  - FB_WORDS=76800
  - typedef pixel_req_t {x[8:0], y[8:0], color[15:0]}
  - enum wr_state_t {IDLE, SETUP, STROBE, HOLD, NEXT}
  - function fb_addr(x,y)
- Sub-module pixel_req_fifo: synchronous FIFO, parameter depth, pixel_req_t payload, full/empty/count, async active-low reset.

Test Plan:
- Grant held, push (x=5,y=2,color=16'h7FFF) → SETUP 2 cycles after push; addr 18'd645; DQ 16'h7FFF; WE_N low exactly 1 cycle; DQ_OE high for 3 cycles.
- Push 16 entries with grant low → oReq_Ready=0 after the 16th, oBus_Req=1, no WE_N activity. Raise grant → 16 writes in push order, 64 cycles total, ready reasserts after the first pop.
- Push (x=320,y=0) and (x=0,y=240) → oErr_Range pulses twice; FIFO stays empty; no SRAM write.
- Clear with color=16'h001F, grant held → 76800 WE_N pulses at addr 0..76799 ascending; oClear_Done once, 1 cycle after the last HOLD.
- Grant toggled off mid-clear at a NEXT boundary → writer parks in IDLE with Req=1. Grant restored → clear resumes at the next address; no address skipped or repeated.
- Assert iRST_N low during STROBE → WE_N=1 and DQ_OE=0 in the same cycle (async). After release all outputs are at reset values and the FIFO is empty.
